// File: rtl/omok_win_checker_if.sv
// Handshake/bus bundle between the game controller and the five-in-a-row checker.
// Latency: none (wires only).
// Backpressure: none; the checker ignores placements while busy or after a win.
interface omok_win_checker_if #(
    parameter int BOARD_N = 10,
    parameter int POS_W   = 8
);
    logic [BOARD_N*BOARD_N-1:0] board_state;
    logic [BOARD_N*BOARD_N-1:0] turn_map;
    logic                       place_pulse;
    logic [POS_W-1:0]           place_pos;
    logic                       new_game;
    logic                       busy;
    logic                       done;
    logic                       win;
    logic                       game_over;
    logic                       winner;

    // Controller side: owns the board view and the placement strobe.
    modport master (
        output board_state, turn_map, place_pulse, place_pos, new_game,
        input  busy, done, win, game_over, winner
    );

    // Checker side.
    modport slave (
        input  board_state, turn_map, place_pulse, place_pos, new_game,
        output busy, done, win, game_over, winner
    );
endinterface

// File: rtl/omok_win_checker.sv
// Sequential five-in-a-row detector: walks 4 lines through the new stone, one neighbour per clock.
// Latency: 2..8 SCAN cycles per direction (max 32), then a 1-cycle DONE; empty cell goes straight to DONE.
// Backpressure: none; placements while busy, in DONE or after a win are dropped, not queued.
module omok_win_checker #(
    parameter int BOARD_N = 10,
    parameter int WIN_LEN = 5,
    parameter int POS_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    omok_win_checker_if.slave bus
);
    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int CW     = POS_W + 2;              // signed row/col, room for off-board excursions
    localparam int STEP_W = $clog2(WIN_LEN) + 1;
    localparam int RUN_W  = $clog2(2 * WIN_LEN) + 1;

    localparam logic [POS_W-1:0]         L_NP       = POS_W'(BOARD_N);
    localparam logic [POS_W-1:0]         L_CELLS    = POS_W'(CELLS);
    localparam logic [IDX_W-1:0]         L_NI       = IDX_W'(BOARD_N);
    localparam logic signed [CW-1:0]     L_N        = CW'(BOARD_N);
    localparam logic [STEP_W-1:0]        L_STEP_MAX = STEP_W'(WIN_LEN - 1);
    localparam logic [RUN_W-1:0]         L_WIN      = RUN_W'(WIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [POS_W-1:0]   r_row,       w_row_nxt;
    logic [POS_W-1:0]   r_col,       w_col_nxt;
    logic               r_colour,    w_colour_nxt;
    logic [1:0]         r_dir,       w_dir_nxt;
    logic               r_side,      w_side_nxt;
    logic [STEP_W-1:0]  r_step,      w_step_nxt;
    logic [RUN_W-1:0]   r_run,       w_run_nxt;
    logic               r_win,       w_win_nxt;
    logic               r_game_over, w_game_over_nxt;
    logic               r_winner,    w_winner_nxt;

    // Placement decode: row/col come from real division so lines never wrap across row edges.
    logic               w_pos_ok;
    logic [IDX_W-1:0]   w_pos_idx;
    logic [POS_W-1:0]   w_pos_row;
    logic [POS_W-1:0]   w_pos_col;
    logic               w_pos_occ;
    logic               w_pos_colour;

    assign w_pos_ok     = (bus.place_pos < L_CELLS);
    assign w_pos_idx    = bus.place_pos[IDX_W-1:0];
    assign w_pos_row    = bus.place_pos / L_NP;
    assign w_pos_col    = bus.place_pos % L_NP;
    assign w_pos_occ    = w_pos_ok && bus.board_state[w_pos_idx];
    assign w_pos_colour = w_pos_ok && bus.turn_map[w_pos_idx];

    // Neighbour coordinates for the current (dir, side, step).
    logic signed [CW-1:0] w_row_s;
    logic signed [CW-1:0] w_col_s;
    logic signed [CW-1:0] w_delta;
    logic signed [CW-1:0] w_nr;
    logic signed [CW-1:0] w_nc;
    logic                 w_inb;
    logic [IDX_W-1:0]     w_nidx;
    logic                 w_match;
    logic [RUN_W-1:0]     w_run_inc;
    logic                 w_side_end;

    assign w_row_s = $signed({2'b00, r_row});
    assign w_col_s = $signed({2'b00, r_col});
    assign w_delta = r_side ? -$signed(CW'(r_step)) : $signed(CW'(r_step));

    // Offset the latched stone along the current direction: E, S, SE, SW (negated on side 1).
    always_comb begin
        w_nr = w_row_s;
        w_nc = w_col_s;
        case (r_dir)
            2'd0: w_nc = w_col_s + w_delta;
            2'd1: w_nr = w_row_s + w_delta;
            2'd2: begin
                w_nr = w_row_s + w_delta;
                w_nc = w_col_s + w_delta;
            end
            default: begin
                w_nr = w_row_s + w_delta;
                w_nc = w_col_s - w_delta;
            end
        endcase
    end

    // Off-board cells are mismatches; the index is only trusted when in bounds.
    assign w_inb      = !w_nr[CW-1] && (w_nr < L_N) && !w_nc[CW-1] && (w_nc < L_N);
    assign w_nidx     = IDX_W'(w_nr) * L_NI + IDX_W'(w_nc);
    assign w_match    = w_inb && bus.board_state[w_nidx] && (bus.turn_map[w_nidx] == r_colour);
    assign w_run_inc  = r_run + RUN_W'(w_match);
    assign w_side_end = !w_match || (r_step == L_STEP_MAX);

    // Next-state and datapath updates for IDLE -> SCAN -> DONE -> IDLE, new_game overriding all.
    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_colour_nxt    = r_colour;
        w_dir_nxt       = r_dir;
        w_side_nxt      = r_side;
        w_step_nxt      = r_step;
        w_run_nxt       = r_run;
        w_win_nxt       = r_win;
        w_game_over_nxt = r_game_over;
        w_winner_nxt    = r_winner;

        case (r_state)
            S_IDLE: begin
                if (bus.place_pulse && !r_game_over) begin
                    w_row_nxt    = w_pos_row;
                    w_col_nxt    = w_pos_col;
                    w_colour_nxt = w_pos_colour;
                    w_dir_nxt    = 2'd0;
                    w_side_nxt   = 1'b0;
                    w_step_nxt   = STEP_W'(1);
                    w_run_nxt    = RUN_W'(1);
                    w_win_nxt    = 1'b0;
                    // An empty cell cannot start a line; report a non-win straight away.
                    w_state_nxt  = w_pos_occ ? S_SCAN : S_DONE;
                end
            end

            S_SCAN: begin
                w_run_nxt = w_run_inc;
                if (!w_side_end) begin
                    w_step_nxt = r_step + STEP_W'(1);
                end else if (!r_side) begin
                    w_side_nxt = 1'b1;
                    w_step_nxt = STEP_W'(1);
                end else if (w_run_inc >= L_WIN) begin
                    w_win_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_dir == 2'd3) begin
                    w_win_nxt   = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_dir_nxt  = r_dir + 2'd1;
                    w_side_nxt = 1'b0;
                    w_step_nxt = STEP_W'(1);
                    w_run_nxt  = RUN_W'(1);
                end
            end

            S_DONE: begin
                if (r_win) begin
                    w_game_over_nxt = 1'b1;
                    w_winner_nxt    = r_colour;
                end
                w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase

        // A new game aborts any scan silently and beats a same-cycle placement.
        if (bus.new_game) begin
            w_state_nxt     = S_IDLE;
            w_game_over_nxt = 1'b0;
            w_winner_nxt    = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_colour    <= 1'b0;
            r_dir       <= 2'd0;
            r_side      <= 1'b0;
            r_step      <= STEP_W'(1);
            r_run       <= RUN_W'(1);
            r_win       <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_colour    <= w_colour_nxt;
            r_dir       <= w_dir_nxt;
            r_side      <= w_side_nxt;
            r_step      <= w_step_nxt;
            r_run       <= w_run_nxt;
            r_win       <= w_win_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    assign bus.busy      = (r_state == S_SCAN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.win       = (r_state == S_DONE) && r_win;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;

endmodule

// File: tb/tb_omok_win_checker.sv
// Bench for omok_win_checker: directed vector table, multi-cycle corner sequences,
// and randomized boards checked against a line-counting reference model.
module tb_omok_win_checker;
    localparam int N   = 10;
    localparam int WIN = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    omok_win_checker_if #(.BOARD_N(N), .POS_W(8)) bus ();

    omok_win_checker #(.BOARD_N(N), .WIN_LEN(WIN), .POS_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [99:0]  board;
        logic [99:0]  tmap;
        int           pos;
        bit           exp_win;
        int           exp_cyc;
        bit           exp_winner;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dr_of(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int dc_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            2:       return 1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [99:0] line_mask(input int start, input int stride, input int cnt);
        logic [99:0] m = '0;
        for (int k = 0; k < cnt; k++) m[start + k*stride] = 1'b1;
        return m;
    endfunction

    function automatic bit same_stone(input logic [99:0] b, input logic [99:0] t,
                                      input int r, input int c, input bit colr);
        if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
        return b[r*N + c] && (t[r*N + c] == colr);
    endfunction

    // Reference: count the contiguous same-colour stones on each side (capped at WIN-1);
    // a side costs one cycle per stone found plus one for the terminating mismatch,
    // except a full side, which stops on its last match.
    function automatic void model(input logic [99:0] b, input logic [99:0] t, input int p,
                                  output bit w, output int cyc);
        int r, c, len, k, sg;
        bit colr;
        w = 1'b0;
        cyc = 0;
        if (!b[p]) return;
        r = p / N;
        c = p % N;
        colr = t[p];
        for (int d = 0; d < 4; d++) begin
            len = 1;
            for (int sd = 0; sd < 2; sd++) begin
                sg = (sd == 0) ? 1 : -1;
                k = 0;
                while (k < WIN-1 && same_stone(b, t, r + sg*(k+1)*dr_of(d), c + sg*(k+1)*dc_of(d), colr))
                    k++;
                len += k;
                cyc += (k == WIN-1) ? k : k + 1;
            end
            if (len >= WIN) begin
                w = 1'b1;
                return;
            end
        end
    endfunction

    task automatic load(input logic [99:0] b, input logic [99:0] t);
        @(negedge clk);
        bus.board_state = b;
        bus.turn_map    = t;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
    endtask

    // Issue one placement and follow the scan to its done pulse (bounded).
    task automatic run_place(input int p, output bit got_done, output bit got_win, output int cyc);
        @(negedge clk);
        bus.place_pos   = 8'(p);
        bus.place_pulse = 1'b1;
        @(negedge clk);
        bus.place_pulse = 1'b0;
        got_done = 1'b0;
        got_win  = 1'b0;
        cyc      = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                got_win  = bus.win;
                break;
            end
            if (bus.busy) cyc++;
            @(negedge clk);
        end
    endtask

    // Count done pulses and busy cycles over a window of clocks.
    task automatic watch(input int ncyc, output int n_done, output int n_busy);
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (bus.busy) n_busy++;
        end
    endtask

    task automatic check_vec(input vec_t v);
        bit gd, gw;
        int cy;
        pulse_new_game();
        load(v.board, v.tmap);
        run_place(v.pos, gd, gw, cy);
        chk({v.name, "_done"}, 32'(gd), 32'd1);
        chk({v.name, "_win"},  32'(gw), 32'(v.exp_win));
        chk({v.name, "_cyc"},  32'(cy), 32'(v.exp_cyc));
        @(negedge clk);
        chk({v.name, "_done_width"}, 32'(bus.done), 32'd0);
        chk({v.name, "_game_over"},  32'(bus.game_over), 32'(v.exp_win));
        chk({v.name, "_winner"},     32'(bus.winner), 32'(v.exp_win & v.exp_winner));
    endtask

    vec_t vecs[6];

    initial begin
        bit gd, gw, mw;
        int cy, mc, nd, nb;
        logic [99:0] b, t;
        int r0, c0, d, len, k, p, rr, cc;
        bit colr;

        bus.board_state = '0;
        bus.turn_map    = '0;
        bus.place_pulse = 1'b0;
        bus.place_pos   = '0;
        bus.new_game    = 1'b0;

        vecs[0] = '{"row_win",    line_mask(40, 1, 5),  '0,                   42, 1'b1, 6,  1'b0};
        vecs[1] = '{"diag4_nowin", line_mask(0, 11, 4), line_mask(0, 11, 4),  33, 1'b0, 11, 1'b1};
        vecs[2] = '{"no_wrap",    line_mask(6, 1, 5),   '0,                   9,  1'b0, 11, 1'b0};
        vecs[3] = '{"anti_diag",  line_mask(9, 9, 5),   line_mask(9, 9, 5),   27, 1'b1, 12, 1'b1};
        vecs[4] = '{"empty_cell", '0,                   '0,                   55, 1'b0, 0,  1'b0};
        vecs[5] = '{"overline",   line_mask(0, 1, 9),   '0,                   4,  1'b1, 8,  1'b0};

        // Reset state.
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_win",  32'(bus.win),  32'd0);
        chk("rst_game_over", 32'(bus.game_over), 32'd0);
        chk("rst_winner", 32'(bus.winner), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 6; i++) check_vec(vecs[i]);

        // Re-pulse while busy and while game_over are both ignored; new_game clears.
        pulse_new_game();
        load(vecs[3].board, vecs[3].tmap);
        @(negedge clk);
        bus.place_pos = 8'd27;
        bus.place_pulse = 1'b1;
        @(negedge clk);
        bus.place_pulse = 1'b0;
        chk("seq_busy_started", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.place_pulse = 1'b1;
        @(negedge clk);
        bus.place_pulse = 1'b0;
        watch(40, nd, nb);
        chk("seq_one_done", 32'(nd), 32'd1);
        chk("seq_game_over", 32'(bus.game_over), 32'd1);
        chk("seq_winner_white", 32'(bus.winner), 32'd1);
        @(negedge clk);
        bus.place_pulse = 1'b1;
        @(negedge clk);
        bus.place_pulse = 1'b0;
        watch(15, nd, nb);
        chk("seq_over_no_done", 32'(nd), 32'd0);
        chk("seq_over_no_busy", 32'(nb), 32'd0);
        pulse_new_game();
        chk("seq_newgame_over", 32'(bus.game_over), 32'd0);
        chk("seq_newgame_winner", 32'(bus.winner), 32'd0);

        // new_game mid-scan aborts without a done pulse.
        load(vecs[0].board, vecs[0].tmap);
        @(negedge clk);
        bus.place_pos = 8'd42;
        bus.place_pulse = 1'b1;
        @(negedge clk);
        bus.place_pulse = 1'b0;
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        watch(15, nd, nb);
        chk("abort_no_done", 32'(nd), 32'd0);

        // new_game beats a same-cycle placement.
        @(negedge clk);
        bus.place_pulse = 1'b1;
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.place_pulse = 1'b0;
        bus.new_game = 1'b0;
        chk("prio_busy", 32'(bus.busy), 32'd0);
        chk("prio_done", 32'(bus.done), 32'd0);

        // Asynchronous reset mid-scan, then the same placement still wins.
        @(negedge clk);
        bus.place_pulse = 1'b1;
        @(negedge clk);
        bus.place_pulse = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_win",  32'(bus.win),  32'd0);
        chk("arst_game_over", 32'(bus.game_over), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_place(42, gd, gw, cy);
        chk("arst_replay_done", 32'(gd), 32'd1);
        chk("arst_replay_win",  32'(gw), 32'd1);
        @(negedge clk);
        chk("arst_replay_over", 32'(bus.game_over), 32'd1);

        // Randomized boards against the reference model.
        for (int trial = 0; trial < 60; trial++) begin
            b = '0;
            t = '0;
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    b[i] = 1'b1;
                    t[i] = 1'($urandom_range(0, 1));
                end
            end
            p = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 1) begin
                r0 = $urandom_range(0, N-1);
                c0 = $urandom_range(0, N-1);
                d = $urandom_range(0, 3);
                len = $urandom_range(3, 7);
                colr = 1'($urandom_range(0, 1));
                for (int j = 0; j < len; j++) begin
                    rr = r0 + j*dr_of(d);
                    cc = c0 + j*dc_of(d);
                    if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
                        b[rr*N + cc] = 1'b1;
                        t[rr*N + cc] = colr;
                    end
                end
                k = $urandom_range(0, len-1);
                rr = r0 + k*dr_of(d);
                cc = c0 + k*dc_of(d);
                p = (rr >= 0 && rr < N && cc >= 0 && cc < N) ? rr*N + cc : r0*N + c0;
            end
            model(b, t, p, mw, mc);
            pulse_new_game();
            load(b, t);
            run_place(p, gd, gw, cy);
            chk("rand_done", 32'(gd), 32'd1);
            chk("rand_win",  32'(gw), 32'(mw));
            chk("rand_cyc",  32'(cy), 32'(mc));
            @(negedge clk);
            chk("rand_game_over", 32'(bus.game_over), 32'(mw));
            chk("rand_winner", 32'(bus.winner), 32'(mw & t[p]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
